fifo_wr_packer: RTL and testbench

//  Write-side packer that sits directly upstream of asyn_fifo in the wr_clk domain.

---
 rtl/fifo_wr_packer.sv | 55 +++++
 tb/tb_fifo_wr_packer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs RATIO narrow valid/ready beats into one FIFO word carrying {last, cnt, lanes}.
module fifo_wr_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO = 4,
  localparam int CNT_W = $clog2(RATIO),
  localparam int OUT_WIDTH = IN_WIDTH * RATIO + CNT_W + 1
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  input  logic                 flush,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [OUT_WIDTH-1:0] fifo_wr_data,
  output logic [15:0]          word_cnt
);
  localparam int ACC_W = IN_WIDTH * RATIO;
  logic [ACC_W-1:0] acc, merged;
  logic [CNT_W-1:0] idx, cnt;
  logic [OUT_WIDTH-1:0] hold;
  logic hold_valid, room, accept, flush_ok, close;
  assign fifo_wr_en = hold_valid & ~fifo_full;
  // hold can take a new word if it is empty or being drained this cycle
  assign room = ~hold_valid | fifo_wr_en;
  assign s_ready = ~wr_rst & room;
  assign fifo_wr_data = hold;
  assign accept = s_valid & s_ready;
  assign flush_ok = flush & room & ((idx != '0) | accept);
  assign close = (accept & ((idx == CNT_W'(RATIO - 1)) | s_last)) | flush_ok;
  assign merged = accept ? (acc | (ACC_W'(s_data) << (idx * IN_WIDTH))) : acc;
  assign cnt = accept ? idx : idx - CNT_W'(1);
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      acc <= '0;
      idx <= '0;
      hold <= '0;
      hold_valid <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (close) begin
        hold <= {accept & s_last, cnt, merged};
        acc <= '0;
        idx <= '0;
      end else if (accept) begin
        acc <= merged;
        idx <= idx + CNT_W'(1);
      end
      hold_valid <= close | (hold_valid & ~fifo_wr_en);
      if (fifo_wr_en) word_cnt <= word_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: randomized and directed checks of fifo_wr_packer against a queue-based word model.
module tb_fifo_wr_packer;
  logic wr_clk, wr_rst, s_valid, s_ready, s_last, flush, fifo_full, fifo_wr_en;
  logic [7:0] s_data;
  logic [34:0] fifo_wr_data;
  logic [15:0] word_cnt;
  int total = 0, bad = 0;
  logic [7:0] cur[$];
  logic [34:0] pend[$];
  logic [34:0] last_wr;
  int nwr = 0;
  logic [15:0] wc = 0;
  logic t;

  fifo_wr_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .flush(flush), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .word_cnt(word_cnt)
  );

  initial wr_clk = 0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // one cycle: drive at negedge, check outputs, advance the model by the pre-edge inputs
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic f,
                      input logic fu, output logic took);
    logic exp_wr, exp_rdy, ftk;
    logic [34:0] w;
    @(negedge wr_clk);
    s_valid = v; s_data = d; s_last = l; flush = f; fifo_full = fu;
    #1;
    exp_wr = (pend.size() > 0) && !fu;
    exp_rdy = (pend.size() == 0) || exp_wr;
    check("s_ready", s_ready, exp_rdy);
    check("wr_en", fifo_wr_en, exp_wr);
    check("word_cnt", word_cnt, wc);
    if (exp_wr) begin
      last_wr = pend.pop_front();
      check("wr_data", fifo_wr_data, last_wr);
      nwr++;
      wc++;
    end
    took = v && exp_rdy;
    ftk = f && exp_rdy && (cur.size() > 0 || took);
    if (took) cur.push_back(d);
    if ((took && (cur.size() == 4 || l)) || ftk) begin
      w = '0;
      foreach (cur[i]) w[i*8 +: 8] = cur[i];
      w[33:32] = 2'(cur.size() - 1);
      w[34] = took && l;
      pend.push_back(w);
      cur.delete();
    end
    @(posedge wr_clk);
  endtask

  task automatic idle(input logic fu);
    logic tk;
    step(0, 8'h00, 0, 0, fu, tk);
  endtask

  initial begin
    int i, guard, n0;
    logic [15:0] wc0;
    logic fu;
    wr_rst = 1; s_valid = 0; s_data = 0; s_last = 0; flush = 0; fifo_full = 0;
    repeat (2) @(negedge wr_clk);
    check("rst_ready", s_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_data", fifo_wr_data, 0);
    check("rst_wc", word_cnt, 0);
    wr_rst = 0;
    // 1: full word
    step(1, 8'h11, 0, 0, 0, t); step(1, 8'h22, 0, 0, 0, t);
    step(1, 8'h33, 0, 0, 0, t); step(1, 8'h44, 0, 0, 0, t);
    idle(0);
    check("t1_word", last_wr, {1'b0, 2'd3, 32'h44332211});
    #1 check("t1_wc", word_cnt, 16'd1);
    // 2: short packet with last; model checks the write lands the cycle after BB
    step(1, 8'hAA, 0, 0, 0, t); step(1, 8'hBB, 1, 0, 0, t);
    n0 = nwr;
    idle(0);
    check("t2_lat", nwr - n0, 1);
    check("t2_word", last_wr, {1'b1, 2'd1, 32'h0000BBAA});
    // 3: hold full, fifo_full high while streaming
    n0 = nwr;
    for (i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, 1, t);
    for (i = 0; i < 10; i++) begin
      step(1, 8'h70, 0, 0, 1, t);
      check("t3_stall", t, 0);
    end
    check("t3_nowr", nwr - n0, 0);
    i = 0; guard = 0;
    while (i < 8 && guard < 100) begin
      step(1, 8'(8'h70 + i), 0, 0, 0, t);
      if (t) i++;
      guard++;
    end
    repeat (3) idle(0);
    check("t3_words", nwr - n0, 3);
    // 4: flush of a partial word, then a flush with nothing open
    step(1, 8'h01, 0, 0, 0, t); step(1, 8'h02, 0, 0, 0, t); step(1, 8'h03, 0, 0, 0, t);
    step(0, 8'h00, 0, 1, 0, t);
    idle(0);
    check("t4_word", last_wr, {1'b0, 2'd2, 32'h00030201});
    n0 = nwr;
    step(0, 8'h00, 0, 1, 0, t);
    idle(0); idle(0);
    check("t4_noflush", nwr - n0, 0);
    // 5: asynchronous reset mid-word
    step(1, 8'hE1, 0, 0, 0, t); step(1, 8'hE2, 0, 0, 0, t);
    s_valid = 0;
    #3 wr_rst = 1;
    #1;
    check("t5_ready", s_ready, 0);
    check("t5_wr_en", fifo_wr_en, 0);
    check("t5_data", fifo_wr_data, 0);
    check("t5_wc", word_cnt, 0);
    cur.delete(); pend.delete(); wc = 0;
    @(negedge wr_clk); wr_rst = 0;
    step(1, 8'h5A, 0, 0, 0, t); step(1, 8'h5B, 0, 0, 0, t);
    step(1, 8'h5C, 0, 0, 0, t); step(1, 8'h5D, 0, 0, 0, t);
    idle(0);
    check("t5_word", last_wr, {1'b0, 2'd3, 32'h5D5C5B5A});
    // 6: 64 back-to-back beats, then again with random full
    wc0 = wc;
    for (i = 0; i < 64; i++) begin
      step(1, 8'(i * 3), 0, 0, 0, t);
      check("t6_accept", t, 1);
    end
    idle(0);
    #1 check("t6_wc", word_cnt, wc0 + 16'd16);
    wc0 = wc;
    i = 0; guard = 0;
    while (i < 64 && guard < 2000) begin
      fu = 1'($urandom_range(0, 1));
      step(1, 8'(i * 5 + 1), 0, 0, fu, t);
      if (t) i++;
      guard++;
    end
    check("t6_done", i, 64);
    repeat (3) idle(0);
    #1 check("t6r_wc", word_cnt, wc0 + 16'd16);
    // random mix of beats, last, flush and full
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0), t);
    repeat (3) idle(0);
    check("drain", pend.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
